// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage_pkg: shared widths and forwarding-bus slice helpers for the operand stage
`define ID_FWD_ADDR(bus, i) bus[(i)*AW +: AW]
`define ID_FWD_DATA(bus, i) bus[(i)*DATA_W +: DATA_W]

package id_operand_stage_pkg;
    localparam int DATA_W    = 32;
    localparam int NREG      = 32;
    localparam int AW        = $clog2(NREG);
    localparam int NFWD      = 3;
    localparam int MAX_LAT   = 7;
    localparam int CW        = $clog2(MAX_LAT + 1);
    localparam int ID_INFO_W = 64;
endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// id_operand_stage_fwd_select: priority forwarding mux for one source operand with load-use detect
module id_operand_stage_fwd_select
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W = id_operand_stage_pkg::DATA_W,
    parameter int AW     = id_operand_stage_pkg::AW,
    parameter int NFWD   = id_operand_stage_pkg::NFWD
) (
    input  logic [AW-1:0]          src,
    input  logic [DATA_W-1:0]      rf_rdata,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_rdy,
    output logic [DATA_W-1:0]      value,
    output logic                   load_use
);
    // walk oldest to youngest so the lowest matching index overrides; $0 overrides everything
    always_comb begin
        value    = rf_rdata;
        load_use = 1'b0;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && `ID_FWD_ADDR(fwd_waddr, i) == src) begin
                value    = `ID_FWD_DATA(fwd_wdata, i);
                load_use = ~fwd_rdy[i];
            end
        end
        if (src == '0) begin
            value    = '0;
            load_use = 1'b0;
        end
    end
endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand fetch, forwarding, hazard stall and EX pipeline register
module id_operand_stage
    import id_operand_stage_pkg::*;
#(
    parameter int DATA_W  = id_operand_stage_pkg::DATA_W,
    parameter int NREG    = id_operand_stage_pkg::NREG,
    parameter int NFWD    = id_operand_stage_pkg::NFWD,
    parameter int MAX_LAT = id_operand_stage_pkg::MAX_LAT,
    localparam int AW     = $clog2(NREG),
    localparam int CW     = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dec_valid,
    output logic                   dec_ready,
    input  logic [AW-1:0]          dec_rs,
    input  logic [AW-1:0]          dec_rt,
    input  logic                   dec_use_rs,
    input  logic                   dec_use_rt,
    input  logic                   dec_we,
    input  logic [AW-1:0]          dec_waddr,
    input  logic [CW-1:0]          dec_lat,
    input  logic [ID_INFO_W-1:0]   dec_info,
    output logic [AW-1:0]          rf_raddr1,
    output logic [AW-1:0]          rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]        fwd_we,
    input  logic [NFWD*AW-1:0]     fwd_waddr,
    input  logic [NFWD*DATA_W-1:0] fwd_wdata,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic                   stall_in,
    input  logic                   flush,
    output logic                   stallreq,
    output logic                   ex_valid,
    output logic [DATA_W-1:0]      ex_a,
    output logic [DATA_W-1:0]      ex_b,
    output logic                   ex_we,
    output logic [AW-1:0]          ex_waddr,
    output logic [ID_INFO_W-1:0]   ex_info
);
    logic [DATA_W-1:0] val_a, val_b;
    logic              lu_a, lu_b, haz_a, haz_b, issue;
    logic [CW-1:0]     sb [NREG];

    id_operand_stage_fwd_select #(.DATA_W(DATA_W), .AW(AW), .NFWD(NFWD)) u_fwd_a (
        .src(dec_rs), .rf_rdata(rf_rdata1), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .value(val_a), .load_use(lu_a)
    );

    id_operand_stage_fwd_select #(.DATA_W(DATA_W), .AW(AW), .NFWD(NFWD)) u_fwd_b (
        .src(dec_rt), .rf_rdata(rf_rdata2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
        .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy), .value(val_b), .load_use(lu_b)
    );

    assign rf_raddr1 = dec_rs;
    assign rf_raddr2 = dec_rt;
    assign haz_a     = dec_use_rs && (lu_a || (dec_rs != '0 && sb[dec_rs] != '0));
    assign haz_b     = dec_use_rt && (lu_b || (dec_rt != '0 && sb[dec_rt] != '0));
    assign stallreq  = dec_valid && (haz_a || haz_b);
    assign dec_ready = ~stallreq && ~stall_in && ~flush;
    assign issue     = dec_valid && dec_ready && dec_we && dec_waddr != '0 && dec_lat != '0;

    // long-latency scoreboard: issue loads the latency, otherwise count down unless frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '{default: '0};
        end else begin
            sb[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && dec_waddr == AW'(r))
                    sb[r] <= dec_lat;
                else if (!stall_in && sb[r] != '0)
                    sb[r] <= sb[r] - CW'(1);
            end
        end
    end

    // EX-facing pipeline register: flush kills, stall_in holds, hazards insert bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_we    <= 1'b0;
            ex_waddr <= '0;
            ex_info  <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (!stall_in) begin
            if (stallreq || !dec_valid) begin
                ex_valid <= 1'b0;
                ex_we    <= 1'b0;
            end else begin
                ex_valid <= 1'b1;
                ex_a     <= val_a;
                ex_b     <= val_b;
                ex_we    <= dec_we;
                ex_waddr <= dec_waddr;
                ex_info  <= dec_info;
            end
        end
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: scoreboard-driven bench for forwarding, hazards, stall/flush and reset
module tb_id_operand_stage;
    import id_operand_stage_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   dec_valid, dec_ready;
    logic [AW-1:0]          dec_rs, dec_rt, dec_waddr;
    logic                   dec_use_rs, dec_use_rt, dec_we;
    logic [CW-1:0]          dec_lat;
    logic [ID_INFO_W-1:0]   dec_info;
    logic [AW-1:0]          rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]        fwd_we, fwd_rdy;
    logic [NFWD*AW-1:0]     fwd_waddr;
    logic [NFWD*DATA_W-1:0] fwd_wdata;
    logic                   stall_in, flush, stallreq;
    logic                   ex_valid, ex_we;
    logic [DATA_W-1:0]      ex_a, ex_b;
    logic [AW-1:0]          ex_waddr;
    logic [ID_INFO_W-1:0]   ex_info;

    typedef struct packed {
        logic [DATA_W-1:0]    a;
        logic [DATA_W-1:0]    b;
        logic                 we;
        logic [AW-1:0]        waddr;
        logic [ID_INFO_W-1:0] info;
    } ex_t;

    ex_t q[$];
    ex_t last;
    int  errors = 0;
    int  checks = 0;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_we(dec_we), .dec_waddr(dec_waddr), .dec_lat(dec_lat), .dec_info(dec_info),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_rdy(fwd_rdy),
        .stall_in(stall_in), .flush(flush), .stallreq(stallreq), .ex_valid(ex_valid),
        .ex_a(ex_a), .ex_b(ex_b), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_info(ex_info)
    );

    always #5 clk = ~clk;

    task automatic set_fwd(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DATA_W-1:0] d, input logic r);
        fwd_we[i]                   = we;
        fwd_waddr[i*AW +: AW]       = a;
        fwd_wdata[i*DATA_W +: DATA_W] = d;
        fwd_rdy[i]                  = r;
    endtask

    task automatic clr_fwd();
        fwd_we    = '0;
        fwd_rdy   = '1;
        fwd_waddr = '0;
        fwd_wdata = '0;
    endtask

    task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic urs, input logic urt, input logic we,
                         input logic [AW-1:0] wa, input logic [CW-1:0] lat,
                         input logic [ID_INFO_W-1:0] info);
        dec_valid  = v;
        dec_rs     = rs;
        dec_rt     = rt;
        dec_use_rs = urs;
        dec_use_rt = urt;
        dec_we     = we;
        dec_waddr  = wa;
        dec_lat    = lat;
        dec_info   = info;
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic we,
                        input logic [AW-1:0] wa, input logic [ID_INFO_W-1:0] info);
        q.push_back('{a: a, b: b, we: we, waddr: wa, info: info});
    endtask

    task automatic tick(input logic exp_valid, input bit pop);
        ex_t e;
        @(posedge clk);
        #1;
        checks++;
        if (ex_valid !== exp_valid) begin
            errors++;
            $display("FAIL ex_valid @%0t: got %b want %b", $time, ex_valid, exp_valid);
        end
        if (pop) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow @%0t", $time);
            end else begin
                e    = q.pop_front();
                last = e;
                if ({ex_a, ex_b, ex_we, ex_waddr, ex_info} !== e) begin
                    errors++;
                    $display("FAIL ex_fields @%0t: got a=%h b=%h we=%b wa=%0d info=%h want a=%h b=%h we=%b wa=%0d info=%h",
                             $time, ex_a, ex_b, ex_we, ex_waddr, ex_info, e.a, e.b, e.we, e.waddr, e.info);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_in = 1'b0;
        flush = 1'b0;
        rf_rdata1 = '0;
        rf_rdata2 = '0;
        clr_fwd();
        drive(0, 5'd7, 5'd13, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ex_valid, ex_a, ex_b, ex_we, ex_waddr, ex_info} !== '0) begin
            errors++;
            $display("FAIL reset_ex: got v=%b a=%h b=%h we=%b wa=%0d info=%h want all 0",
                     ex_valid, ex_a, ex_b, ex_we, ex_waddr, ex_info);
        end
        checks++;
        if (rf_raddr1 !== 5'd7 || rf_raddr2 !== 5'd13) begin
            errors++;
            $display("FAIL rf_raddr: got %0d/%0d want 7/13", rf_raddr1, rf_raddr2);
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        rf_rdata1 = 32'h1111;
        rf_rdata2 = 32'h2222;
        set_fwd(0, 1, 5'd5, 32'hAAAA, 1);
        set_fwd(2, 1, 5'd5, 32'hBBBB, 1);
        drive(1, 5'd5, 5'd0, 1, 0, 1, 5'd3, 0, 64'hC0DE_0001);
        checks++;
        if (stallreq !== 1'b0 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_handshake: stallreq=%b dec_ready=%b want 0/1", stallreq, dec_ready);
        end
        push(32'hAAAA, 32'h0, 1, 5'd3, 64'hC0DE_0001);
        tick(1, 1);
        set_fwd(0, 0, 5'd5, 32'hAAAA, 1);
        drive(1, 5'd5, 5'd0, 1, 0, 1, 5'd4, 0, 64'hC0DE_0002);
        push(32'hBBBB, 32'h0, 1, 5'd4, 64'hC0DE_0002);
        tick(1, 1);
        set_fwd(2, 0, 5'd5, 32'hBBBB, 1);
        drive(1, 5'd5, 5'd5, 1, 1, 0, 5'd6, 0, 64'hC0DE_0003);
        push(32'h1111, 32'h2222, 0, 5'd6, 64'hC0DE_0003);
        tick(1, 1);
    endtask

    task automatic test_zero();
        clr_fwd();
        set_fwd(0, 1, 5'd0, 32'hFFFF_FFFF, 0);
        rf_rdata1 = 32'h1234;
        drive(1, 5'd0, 5'd0, 1, 1, 0, 0, 0, 64'hC0DE_0010);
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL zero_stall: got %b want 0", stallreq);
        end
        push(32'h0, 32'h0, 0, 0, 64'hC0DE_0010);
        tick(1, 1);
    endtask

    task automatic test_load_use();
        clr_fwd();
        rf_rdata2 = 32'h77;
        set_fwd(0, 1, 5'd8, 32'h44, 0);
        drive(1, 5'd0, 5'd8, 0, 1, 0, 0, 0, 64'hC0DE_0020);
        checks++;
        if (stallreq !== 1'b1 || dec_ready !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_stall: stallreq=%b dec_ready=%b want 1/0", stallreq, dec_ready);
        end
        tick(0, 0);
        set_fwd(0, 1, 5'd8, 32'h55, 1);
        #1;
        checks++;
        if (stallreq !== 1'b0 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_release: stallreq=%b dec_ready=%b want 0/1", stallreq, dec_ready);
        end
        push(32'h0, 32'h55, 0, 0, 64'hC0DE_0020);
        tick(1, 1);
        set_fwd(0, 1, 5'd8, 32'h66, 0);
        drive(1, 5'd0, 5'd8, 0, 0, 0, 0, 0, 64'hC0DE_0021);
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_unused: stallreq=%b want 0", stallreq);
        end
        push(32'h0, 32'h66, 0, 0, 64'hC0DE_0021);
        tick(1, 1);
    endtask

    task automatic test_scoreboard();
        clr_fwd();
        rf_rdata1 = 32'h99;
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 3'd3, 64'hC0DE_0030);
        push(32'h0, 32'h0, 1, 5'd9, 64'hC0DE_0030);
        tick(1, 1);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 0, 0, 64'hC0DE_0031);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (stallreq !== 1'b1 || dec_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_stall[%0d]: stallreq=%b dec_ready=%b want 1/0", k, stallreq, dec_ready);
            end
            tick(0, 0);
        end
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL sb_release: stallreq=%b want 0", stallreq);
        end
        push(32'h99, 32'h0, 0, 0, 64'hC0DE_0031);
        tick(1, 1);
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 3'd3, 64'hC0DE_0032);
        push(32'h0, 32'h0, 1, 5'd9, 64'hC0DE_0032);
        tick(1, 1);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 0, 0, 64'hC0DE_0033);
        for (int k = 0; k < 5; k++) begin
            stall_in = (k < 2);
            #1;
            checks++;
            if (stallreq !== 1'b1 || dec_ready !== 1'b0) begin
                errors++;
                $display("FAIL sb_frozen_stall[%0d]: stallreq=%b dec_ready=%b want 1/0", k, stallreq, dec_ready);
            end
            tick(k < 2, 0);
        end
        stall_in = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0) begin
            errors++;
            $display("FAIL sb_frozen_release: stallreq=%b want 0", stallreq);
        end
        push(32'h99, 32'h0, 0, 0, 64'hC0DE_0033);
        tick(1, 1);
    endtask

    task automatic test_flush_stall();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd12, 3'd7, 64'hC0DE_0040);
        push(32'h0, 32'h0, 1, 5'd12, 64'hC0DE_0040);
        tick(1, 1);
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd2, 0, 64'hC0DE_0041);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (dec_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready[%0d]: dec_ready=%b want 0", k, dec_ready);
            end
            tick(1, 0);
            checks++;
            if ({ex_a, ex_b, ex_we, ex_waddr, ex_info} !== last) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got a=%h we=%b wa=%0d info=%h want a=%h we=%b wa=%0d info=%h",
                         k, ex_a, ex_we, ex_waddr, ex_info, last.a, last.we, last.waddr, last.info);
            end
        end
        stall_in = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if (dec_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: dec_ready=%b want 0", dec_ready);
        end
        tick(0, 0);
        flush = 1'b0;
        drive(1, 5'd12, 5'd0, 1, 0, 0, 0, 0, 64'hC0DE_0042);
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("FAIL flush_keeps_sb: stallreq=%b want 1", stallreq);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 3'd5, 64'hC0DE_0050);
        push(32'h0, 32'h0, 1, 5'd9, 64'hC0DE_0050);
        tick(1, 1);
        drive(1, 5'd9, 5'd0, 1, 0, 0, 0, 0, 64'hC0DE_0051);
        checks++;
        if (stallreq !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_stall: stallreq=%b want 1", stallreq);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (stallreq !== 1'b0 || dec_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_stall: stallreq=%b dec_ready=%b want 0/1", stallreq, dec_ready);
        end
        checks++;
        if ({ex_valid, ex_a, ex_b, ex_we, ex_waddr, ex_info} !== '0) begin
            errors++;
            $display("FAIL post_reset_ex: got v=%b a=%h b=%h we=%b wa=%0d info=%h want all 0",
                     ex_valid, ex_a, ex_b, ex_we, ex_waddr, ex_info);
        end
        push(32'h99, 32'h0, 0, 0, 64'hC0DE_0051);
        tick(1, 1);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_zero();
        test_load_use();
        test_scoreboard();
        test_flush_stall();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
